multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Control FSM for the multicycle ARM-subset datapath (PC, instr/data memory, register file, ALU, extender).
//  Decodes the latched instruction and sequences fetch/decode/execute/writeback one state per clock.
//  Holds the NZCV flags and gates every architectural write with the instruction's condition field.
//  Drives the mux selects (RegSrc, ImmSrc, ALUSrcA/B, ResultSrc, AdrSrc) and all write enables.
// PARAMETERS
//  STATE_W   4   state register width (10 states used)
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low reset
//  Instr      in   32  instruction register contents; uses [31:28] Cond, [27:26] Op, [25:20] Funct, [15:12] Rd
//  ALUFlags   in   4   {N,Z,C,V} from ALU, current cycle
//  PCWrite    out  1   PC register enable
//  IRWrite    out  1   instruction register enable
//  MemWrite   out  1   data memory write enable
//  RegWrite   out  1   register file write enable (WE3)
//  AdrSrc     out  1   memory address: 0=PC, 1=ALU result
//  RegSrc     out  2   [0]=1: RA1=R15; [1]=1: RA2=Rd (STR)
//  ImmSrc     out  2   00 imm8, 01 imm12, 10 imm24 branch (= Op)
//  ALUSrcA    out  1   0=RD1, 1=PC
//  ALUSrcB    out  2   00 RD2, 01 ExtImm, 10 const 4
//  ResultSrc  out  2   00 ALUOut reg, 01 Data reg, 10 ALU result (direct)
//  ALUControl out  2   00 ADD, 01 SUB, 10 AND, 11 ORR
// BEHAVIOUR
//  States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
//  - FETCH -> DECODE.
//  - DECODE -> Op 01: MEMADR; Op 00 with Funct[5]=1: EXECI, else EXECR; Op 10: BRANCH; Op 11: FETCH (illegal, no writes).
//  - MEMADR -> Funct[0]=1 (LDR): MEMREAD, else MEMWRITE.
//  - MEMREAD -> MEMWB -> FETCH; MEMWRITE -> FETCH.
//  - EXECR/EXECI -> ALUWB -> FETCH; BRANCH -> FETCH.
//  Outputs are Moore, per state; anything not listed is 0 or don't-care-driven-0.
//  - FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
//  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10 (R15 reads PC+8).
//  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD (U bit ignored).
//  - MEMREAD: AdrSrc=1, ResultSrc=00.
//  - MEMWB: ResultSrc=01, RegWrite=CondEx.
//  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=CondEx.
//  - EXECR/EXECI: ALUSrcA=0, ALUSrcB=00/01, ALUControl from cmd.
//  - ALUWB: ResultSrc=00, RegWrite=CondEx & ~CMP.
//  - BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx.
//  Write to R15: in MEMWB or ALUWB with Rd=15, PCWrite also = CondEx.
//  RegSrc and ImmSrc are combinational from Instr in every state:
//  - RegSrc = {Op==01, Op==10}; ImmSrc = Op.
//  cmd = Funct[4:1]:
//  - ADD 0100 -> ADD; SUB 0010 -> SUB; AND 0000 -> AND; ORR 1100 -> ORR; CMP 1010 -> SUB, no writeback.
//  - Any other cmd: ALUControl=ADD and RegWrite suppressed.
//  Flags register (4b), reset to 0000.
//  - Updated at the clock edge ending EXECR/EXECI when Funct[0]=1 (S) and CondEx.
//  - NZ always load; CV load only for ADD/SUB/CMP.
//  CondEx is combinational from Cond and the flags register:
//  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
//  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
//  - AL (1110) = 1; 1111 = 0.
//  - A failed condition still walks every state (fixed latency) but suppresses all architectural writes.
//  - The FETCH/DECODE PC increment and IRWrite are never gated.
//  Latency (cycles): LDR 5, STR 4, data-processing 4, B 3, illegal 2.
//  Reset low, at any time including mid-instruction:
//  - state=FETCH immediately, flags=0000, and all enables (PCWrite, IRWrite, MemWrite, RegWrite) forced 0 while low.
//  - First rising edge after release performs FETCH.
// CONFIGURATION
//  MC_CTRL_PERF_EN defined adds outputs:
//  - cycle_count[31:0]: +1 every clock while out of reset.
//  - instr_count[31:0]: +1 on every transition into FETCH, including condition-failed and illegal instructions.
//  Both counters reset to 0 and wrap 0xFFFFFFFF -> 0.
//  Undefined: ports and logic absent; behaviour otherwise identical.
// TESTING
//  1. Hold reset low 3 cycles, release -> all enables 0 during reset; cycle 1 IRWrite=1, PCWrite=1; flags=0000.
//  2. ADD R1,R2,#5 (E2821005) -> FETCH, DECODE, EXECI, ALUWB; RegWrite=1 only in ALUWB, ALUSrcB=01, ALUControl=00.
//  3. SUBS R0,R0,R0 with ALUFlags=0110, then BEQ (0A000002) -> Z latched; BRANCH PCWrite=1; BNE (1A...) PCWrite=0 in BRANCH.
//  4. LDR R3,[R0,#8] (E5903008) -> 5 cycles, AdrSrc=1 in MEMREAD, ResultSrc=01 and RegWrite=1 in MEMWB.
//  5. STR with Cond=NE and Z=1 -> MemWrite stays 0 in MEMWRITE; next FETCH on cycle 5.
//  6. Drop reset in MEMREAD -> enables 0 at once, restart in FETCH; with MC_CTRL_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle ARM-subset datapath: decode, sequencing, NZCV flags, condition gating.
// Optional build macro MC_CTRL_PERF_EN adds cycle_count/instr_count performance counters.
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUControl
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  state_t state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cmd;
  logic       unused_instr;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  assign cmd   = funct[4:1];
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  logic [1:0] alu_cmd;
  logic       cmd_valid, cmd_cmp, cmd_arith;

  always_comb begin
    alu_cmd   = 2'b00;
    cmd_valid = 1'b1;
    cmd_cmp   = 1'b0;
    cmd_arith = 1'b0;
    case (cmd)
      4'b0100: cmd_arith = 1'b1;
      4'b0010: begin alu_cmd = 2'b01; cmd_arith = 1'b1; end
      4'b0000: alu_cmd = 2'b10;
      4'b1100: alu_cmd = 2'b11;
      4'b1010: begin alu_cmd = 2'b01; cmd_arith = 1'b1; cmd_cmp = 1'b1; end
      default: cmd_valid = 1'b0;
    endcase
  end

  logic fn, fz, fc, fv, cond_ex;
  assign {fn, fz, fc, fv} = flags_q;

  always_comb begin
    case (cond)
      4'h0: cond_ex = fz;
      4'h1: cond_ex = ~fz;
      4'h2: cond_ex = fc;
      4'h3: cond_ex = ~fc;
      4'h4: cond_ex = fn;
      4'h5: cond_ex = ~fn;
      4'h6: cond_ex = fv;
      4'h7: cond_ex = ~fv;
      4'h8: cond_ex = fc & ~fz;
      4'h9: cond_ex = ~fc | fz;
      4'hA: cond_ex = (fn == fv);
      4'hB: cond_ex = (fn != fv);
      4'hC: cond_ex = ~fz & (fn == fv);
      4'hD: cond_ex = fz | (fn != fv);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = funct[5] ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECR,
      EXECI:    state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  // N/Z load on any flag-setting op; C/V only when the ALU did arithmetic.
  always_comb begin
    flags_d = flags_q;
    if ((state_q == EXECR || state_q == EXECI) && funct[0] && cond_ex) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (cmd_arith) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  logic pc_write_c, ir_write_c, mem_write_c, reg_write_c;

  always_comb begin
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    ALUControl  = 2'b00;
    case (state_q)
      FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_c = cond_ex;
        pc_write_c  = cond_ex & (rd == 4'd15);
      end
      MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_c = cond_ex;
      end
      EXECR:    ALUControl = alu_cmd;
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_cmd;
      end
      ALUWB: begin
        reg_write_c = cond_ex & cmd_valid & ~cmd_cmp;
        pc_write_c  = cond_ex & cmd_valid & ~cmd_cmp & (rd == 4'd15);
      end
      BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        pc_write_c = cond_ex;
      end
      default: ;
    endcase
  end

  // Reset is asynchronous, so the enables must drop the instant it goes low.
  assign PCWrite  = pc_write_c & reset;
  assign IRWrite  = ir_write_c & reset;
  assign MemWrite = mem_write_c & reset;
  assign RegWrite = reg_write_c & reset;
  assign RegSrc   = {op == 2'b01, op == 2'b10};
  assign ImmSrc   = op;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] instr_count_q, instr_count_d;

  always_comb begin
    cycle_count_d = cycle_count_q + 32'd1;
    instr_count_d = instr_count_q;
    if (state_d == FETCH) instr_count_d = instr_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count_q <= 32'd0;
      instr_count_q <= 32'd0;
    end else begin
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
`endif

endmodule
